// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction-fetch stage.
package fetch_pkg;

   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

   // One buffered fetch result: instruction word, its PC and the NPC predicted at fetch time.
   typedef struct packed {
      logic [31:0] inst;
      logic [31:0] pc;
      logic [31:0] pred_npc;
   } fetch_entry_t;

   localparam int unsigned FETCH_ENTRY_W = $bits(fetch_entry_t);

endpackage

// File: rtl/fetch_fifo.sv
// Small circular FIFO holding tagged fetch results; flush has priority over push and pop.
module fetch_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 96
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   input  logic                     flush,
   output logic                     head_valid,
   output logic [WIDTH-1:0]         head_data,
   output logic [$clog2(DEPTH):0]   occupancy
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;
   localparam logic [PW-1:0] PTR_ONE = 1;
   localparam logic [CW-1:0] CNT_ONE = 1;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PW-1:0]    r_wr_ptr;
   logic [PW-1:0]    r_rd_ptr;
   logic [CW-1:0]    r_count;

   logic w_push_en;
   logic w_pop_en;

   assign w_push_en  = push && !flush;
   assign w_pop_en   = pop && !flush && (r_count != '0);
   assign head_valid = (r_count != '0);
   assign head_data  = r_mem[r_rd_ptr];
   assign occupancy  = r_count;

   // Storage array; no reset needed since entries are only read when counted valid.
   always_ff @(posedge clk) begin
      if (w_push_en) begin
         r_mem[r_wr_ptr] <= push_data;
      end
   end

   // Pointer and count update; pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push_en) begin
            r_wr_ptr <= r_wr_ptr + PTR_ONE;
         end
         if (w_pop_en) begin
            r_rd_ptr <= r_rd_ptr + PTR_ONE;
         end
         unique case ({w_push_en, w_pop_en})
            2'b10:   r_count <= r_count + CNT_ONE;
            2'b01:   r_count <= r_count - CNT_ONE;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/fetch_queue.sv
// Fetch stage: PC register, one-deep in-flight tracker for the synchronous imem, and a
// tagged-instruction FIFO towards decode. Redirect discards all wrong-path state.
module fetch_queue
   import fetch_pkg::*;
#(
   parameter int unsigned DEPTH    = 4,
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [31:0]              npc,
   input  logic                     redirect,
   output logic [31:0]              pc_if,
   output logic [31:0]              pc_plus4,
   output logic                     imem_req,
   output logic [31:0]              imem_addr,
   input  logic [31:0]              imem_rdata,
   output logic                     id_valid,
   input  logic                     id_ready,
   output logic [31:0]              id_inst,
   output logic [31:0]              id_pc,
   output logic [31:0]              id_pred_npc,
   output logic [$clog2(DEPTH):0]   occupancy
);

   localparam int unsigned CW = $clog2(DEPTH) + 1;
   localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

   logic [31:0]  r_pc;
   logic         r_inflight_v;
   logic [31:0]  r_inflight_pc;
   logic [31:0]  r_inflight_pred;

   logic [CW:0]  w_used;
   logic         w_issue;
   logic         w_push;
   logic         w_pop;
   logic         w_head_valid;
   fetch_entry_t w_push_entry;
   fetch_entry_t w_head;

   // Slots already committed = buffered entries plus the response still on its way back.
   assign w_used   = {1'b0, occupancy} + {{CW{1'b0}}, r_inflight_v};
   assign w_issue  = !redirect && (w_used < DEPTH_W);

   assign pc_if     = r_pc;
   assign pc_plus4  = r_pc + 32'd4;
   assign imem_addr = r_pc;
   assign imem_req  = w_issue && rst_n;

   assign w_push = r_inflight_v && !redirect;
   assign w_pop  = w_head_valid && id_ready && !redirect;

   // Tag the returning word with the PC and prediction captured at request time.
   always_comb begin
      w_push_entry          = '0;
      w_push_entry.inst     = imem_rdata;
      w_push_entry.pc       = r_inflight_pc;
      w_push_entry.pred_npc = r_inflight_pred;
   end

   // PC register and in-flight tracker; redirect overrides issue.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pc            <= RESET_PC;
         r_inflight_v    <= 1'b0;
         r_inflight_pc   <= '0;
         r_inflight_pred <= '0;
      end else if (redirect) begin
         r_pc         <= npc;
         r_inflight_v <= 1'b0;
      end else if (w_issue) begin
         r_pc            <= npc;
         r_inflight_v    <= 1'b1;
         r_inflight_pc   <= r_pc;
         r_inflight_pred <= npc;
      end else begin
         r_inflight_v <= 1'b0;
      end
   end

   fetch_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (FETCH_ENTRY_W)
   ) u_fifo (
      .clk        (clk),
      .rst_n      (rst_n),
      .push       (w_push),
      .push_data  (w_push_entry),
      .pop        (w_pop),
      .flush      (redirect),
      .head_valid (w_head_valid),
      .head_data  (w_head),
      .occupancy  (occupancy)
   );

   assign id_valid    = w_head_valid;
   assign id_inst     = w_head.inst;
   assign id_pc       = w_head.pc;
   assign id_pred_npc = w_head.pred_npc;

endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: stimulus queues expected ID entries, a monitor checks them.
module tb_fetch_queue;

   localparam int unsigned DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] npc;
   logic        redirect = 1'b0;
   logic [31:0] pc_if;
   logic [31:0] pc_plus4;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata = 32'h0;
   logic        id_valid;
   logic        id_ready = 1'b0;
   logic [31:0] id_inst;
   logic [31:0] id_pc;
   logic [31:0] id_pred_npc;
   logic [2:0]  occupancy;

   logic        use_tgt = 1'b0;
   logic [31:0] tgt = 32'h0;
   logic        taken_en = 1'b0;

   int checks = 0;
   int errors = 0;
   int pops = 0;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] pred;
   } exp_t;
   exp_t exp_q[$];
   exp_t mon_e;

   fetch_queue #(
      .DEPTH    (DEPTH),
      .RESET_PC (32'h0000_0000)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .npc         (npc),
      .redirect    (redirect),
      .pc_if       (pc_if),
      .pc_plus4    (pc_plus4),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_rdata  (imem_rdata),
      .id_valid    (id_valid),
      .id_ready    (id_ready),
      .id_inst     (id_inst),
      .id_pc       (id_pc),
      .id_pred_npc (id_pred_npc),
      .occupancy   (occupancy)
   );

   always #5 clk = ~clk;

   // Next-PC generator model: explicit target, one predicted-taken branch at 0x10, else +4.
   assign npc = use_tgt ? tgt : ((taken_en && pc_if == 32'h10) ? 32'h80 : pc_if + 32'd4);

   // Synchronous instruction memory: word at address A is ~A.
   always @(posedge clk) imem_rdata <= ~imem_addr;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic exp_push(input logic [31:0] pc, input logic [31:0] pred);
      exp_t e;
      e.pc = pc;
      e.pred = pred;
      exp_q.push_back(e);
   endtask

   task automatic exp_seq(input logic [31:0] start, input int n);
      for (int i = 0; i < n; i++) begin
         exp_push(start + 32'(4 * i), start + 32'(4 * i + 4));
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      @(negedge clk);
      chk("rst_imem_req", 32'(imem_req), 32'h0);
      chk("rst_id_valid", 32'(id_valid), 32'h0);
      chk("rst_occupancy", 32'(occupancy), 32'h0);
      chk("rst_pc_if", pc_if, 32'h0);
      exp_q.delete();
      pops = 0;
      tick();
      rst_n = 1'b1;
   endtask

   task automatic phase_end(input string name);
      chk(name, 32'(exp_q.size()), 32'h0);
   endtask

   // Monitor: every accepted head must match the next expected entry.
   always @(negedge clk) begin
      if (rst_n && id_valid && id_ready && !redirect) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_pop actual_pc=%h required=none", id_pc);
         end else begin
            mon_e = exp_q.pop_front();
            chk("id_pc", id_pc, mon_e.pc);
            chk("id_pred_npc", id_pred_npc, mon_e.pred);
            chk("id_inst", id_inst, ~mon_e.pc);
         end
         pops++;
      end
   end

   initial begin
      // Free run, ID always ready.
      id_ready = 1'b1;
      do_reset();
      exp_seq(32'h0, 8);
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         chk("p1_req", 32'(imem_req), 32'h1);
         chk("p1_addr", imem_addr, 32'(4 * (k - 1)));
         chk("p1_valid", 32'(id_valid), 32'(k >= 3));
         tick();
      end
      phase_end("p1_drain");

      // Backpressure from reset, then release.
      id_ready = 1'b0;
      do_reset();
      exp_seq(32'h0, 8);
      for (int k = 1; k <= 16; k++) begin
         if (k == 9) id_ready = 1'b1;
         @(negedge clk);
         if (k <= 4) begin
            chk("p2_req", 32'(imem_req), 32'h1);
            chk("p2_addr", imem_addr, 32'(4 * (k - 1)));
         end else if (k <= 8) begin
            chk("p2_stall_req", 32'(imem_req), 32'h0);
            chk("p2_stall_pc", pc_if, 32'h10);
         end
         if (k == 6 || k == 8) chk("p2_full", 32'(occupancy), 32'h4);
         tick();
      end
      phase_end("p2_drain");

      // Redirect with 3 buffered entries and one in flight.
      id_ready = 1'b0;
      do_reset();
      exp_seq(32'h200, 3);
      for (int k = 1; k <= 10; k++) begin
         if (k == 5) begin
            redirect = 1'b1;
            use_tgt = 1'b1;
            tgt = 32'h200;
         end else if (k == 6) begin
            redirect = 1'b0;
            use_tgt = 1'b0;
            id_ready = 1'b1;
         end
         @(negedge clk);
         if (k == 5) begin
            chk("p3_pre_occ", 32'(occupancy), 32'h3);
            chk("p3_redir_req", 32'(imem_req), 32'h0);
         end
         if (k == 6) begin
            chk("p3_occ", 32'(occupancy), 32'h0);
            chk("p3_valid", 32'(id_valid), 32'h0);
            chk("p3_addr", imem_addr, 32'h200);
            chk("p3_req", 32'(imem_req), 32'h1);
         end
         if (k == 7) chk("p3_valid_t2", 32'(id_valid), 32'h0);
         if (k == 8) chk("p3_valid_t3", 32'(id_valid), 32'h1);
         tick();
      end
      phase_end("p3_drain");

      // Predicted-taken branch at 0x10 -> 0x80.
      id_ready = 1'b1;
      taken_en = 1'b1;
      do_reset();
      exp_seq(32'h0, 4);
      exp_push(32'h10, 32'h80);
      exp_seq(32'h80, 3);
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         if (k == 5) chk("p4_addr_br", imem_addr, 32'h10);
         if (k == 6) chk("p4_addr_tgt", imem_addr, 32'h80);
         tick();
      end
      taken_en = 1'b0;
      phase_end("p4_drain");

      // PC wrap at the top of the address space.
      id_ready = 1'b1;
      do_reset();
      exp_push(32'hFFFF_FFF8, 32'hFFFF_FFFC);
      exp_push(32'hFFFF_FFFC, 32'h0);
      exp_seq(32'h0, 2);
      for (int k = 1; k <= 7; k++) begin
         if (k == 1) begin
            redirect = 1'b1;
            use_tgt = 1'b1;
            tgt = 32'hFFFF_FFF8;
         end else begin
            redirect = 1'b0;
            use_tgt = 1'b0;
         end
         @(negedge clk);
         if (k == 2) chk("p6_addr", imem_addr, 32'hFFFF_FFF8);
         if (k == 3) begin
            chk("p6_pc_top", pc_if, 32'hFFFF_FFFC);
            chk("p6_plus4", pc_plus4, 32'h0);
         end
         if (k == 4) chk("p6_pc_wrap", pc_if, 32'h0);
         tick();
      end
      phase_end("p6_drain");

      // 20 instructions with a random ready pattern across pointer wrap.
      id_ready = 1'b0;
      do_reset();
      exp_seq(32'h0, 20);
      for (int c = 0; c < 400 && pops < 20; c++) begin
         id_ready = ($urandom_range(0, 3) != 0);
         @(negedge clk);
         tick();
      end
      id_ready = 1'b0;
      chk("p5_count", 32'(pops), 32'd20);
      phase_end("p5_drain");

      // Asynchronous reset with a full FIFO.
      id_ready = 1'b0;
      do_reset();
      for (int k = 1; k <= 7; k++) begin
         @(negedge clk);
         if (k == 7) chk("p7_full", 32'(occupancy), 32'h4);
         tick();
      end
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("p7_async_valid", 32'(id_valid), 32'h0);
      chk("p7_async_occ", 32'(occupancy), 32'h0);
      chk("p7_async_pc", pc_if, 32'h0);
      chk("p7_async_req", 32'(imem_req), 32'h0);
      exp_q.delete();
      pops = 0;
      tick();
      rst_n = 1'b1;
      id_ready = 1'b1;
      exp_seq(32'h0, 3);
      for (int k = 1; k <= 5; k++) begin
         @(negedge clk);
         if (k == 1) begin
            chk("p7_restart_req", 32'(imem_req), 32'h1);
            chk("p7_restart_addr", imem_addr, 32'h0);
         end
         tick();
      end
      phase_end("p7_drain");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
